spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parametrised SPI master, successor to the fixed 8-bit mode-0 master. Adds configurable word width, programmable SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first ordering and multiple chip selects. Full duplex: shifts data_in out on mosi while capturing miso into data_out. Sits between the local control logic (load/ready/done handshake) and external SPI slaves.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
NUM_CS, 1, number of chip-select lines (>=1)
CS_SEL_W, 1, width of cs_sel; must be >= max(1, clog2(NUM_CS))

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  DATA_WIDTH  word to transmit, sampled on accepted load
load  input  1  start request; accepted when load && ready
cs_sel  input  CS_SEL_W  target slave index, sampled on accepted load
cpol  input  1  clock polarity, sampled on accepted load
cpha  input  1  clock phase, sampled on accepted load
lsb_first  input  1  1 = LSB shifted first, sampled on accepted load
data_out  output  DATA_WIDTH  received word, valid from done, held until next done
ready  output  1  idle, can accept load
done  output  1  single-cycle end-of-transfer pulse
mosi  output  1  serial data out
miso  input  1  serial data in
sclk  output  1  SPI clock
cs_n  output  NUM_CS  active-low chip selects

Behaviour:
- Reset (async, reset=0): ready=1, done=0, data_out=0, mosi=0, sclk=0, cs_n=all 1s, latched mode=0, FSM=IDLE. Applies immediately mid-transfer; the aborted word is discarded and done is not pulsed.
- All outputs registered. FSM: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
- IDLE: ready=1, sclk=latched cpol. On load && ready at edge T0: latch data_in, cs_sel, cpol, cpha and lsb_first; ready=0; cs_n[cs_sel]=0; sclk=cpol; mosi=first bit (data_in[W-1], or data_in[0] if lsb_first). Go to SETUP.
- cs_sel >= NUM_CS: transfer runs normally with all cs_n high.
- load while ready=0: ignored. Mode/data inputs are don't-care outside the load cycle.
- SETUP: lasts CLK_DIV cycles. SCLK edges then occur at T0+k*CLK_DIV, k=1..2*DATA_WIDTH (TRANSFER). Odd k = leading edge, even k = trailing edge.
- CPHA=0: sample miso on leading edges; drive next bit on trailing edges k<2W. mosi holds the last bit after edge 2W.
- CPHA=1: drive bit on each leading edge (the first bit is re-driven at k=1); sample on trailing edges.
- Received bits fill data_out in the same order as transmit: MSB-first shifts in at LSB; lsb_first shifts in at MSB.
- HOLD: CLK_DIV cycles, sclk=cpol. At T0+(2W+1)*CLK_DIV: cs_n all high, data_out updated, done=1 for exactly one cycle, ready=1, FSM=IDLE.
- Latency from load edge to done is (2*DATA_WIDTH+1)*CLK_DIV clk cycles. For W=8 and CLK_DIV=2 this is 34.
- load may be asserted in the done cycle (ready=1) and is accepted for back-to-back operation. cs_n then re-asserts on the next edge.
- Divider counter width clog2(CLK_DIV)+1; bit counter width clog2(2*DATA_WIDTH)+1. No wrap inside a transfer.

Optional Feature:
Macro SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the receive path samples internal mosi instead of the miso pin, and cs_n stays all high for the whole transfer. Timing and done are unchanged, so data_out equals data_in.
- Not defined: no loopback port; miso is always sampled.

Test Plan:
1. W=8, CLK_DIV=2, mode 0, MSB-first, data_in=0xA5; slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 valid at leading edges; data_out=0x3C; done exactly 34 cycles after load; cs_n low throughout.
2. Mode 3 (cpol=1, cpha=1), lsb_first=1, data_in=0x81, slave returns 0x0F (LSB-first) -> sclk idles high; mosi changes on falling edges; data_out=0x0F.
3. NUM_CS=4, cs_sel=2 -> cs_n=4'b1011 during transfer. Repeat with cs_sel=3 -> 4'b0111. Idle value is 4'b1111.
4. Load pulsed again 5 cycles into a transfer with a different data_in -> ignored; single done; data_out matches the first transfer only.
5. reset driven low at cycle 10 of a transfer -> same cycle: cs_n all 1, sclk=0, ready=1, done never pulses. A new load after release completes normally.
6. SPI_LOOPBACK_EN defined, loopback=1, data_in=0x5A -> data_out=0x5A, cs_n stays high; back-to-back load in the done cycle accepted.

Source files
------------

// File: rtl/spi_master_param_if.sv
// Local-side transfer bundle for spi_master_param: word, mode and slave select in; received word and status out.
// master = control logic issuing transfers, slave = the SPI engine serving them.
interface spi_master_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CS_SEL_W   = 1
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load;
    logic [CS_SEL_W-1:0]   cs_sel;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  done;

    modport master (output data_in, load, cs_sel, cpol, cpha, lsb_first,
                    input  data_out, ready, done);
    modport slave  (input  data_in, load, cs_sel, cpol, cpha, lsb_first,
                    output data_out, ready, done);
endinterface

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: DATA_WIDTH words, CLK_DIV divider, CPOL/CPHA, MSB/LSB-first, NUM_CS selects; option SPI_LOOPBACK_EN.
// Latency load->done (2*DATA_WIDTH+1)*CLK_DIV clk; load is ignored while ready=0 (no queueing).
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_CS     = 1,
    parameter int CS_SEL_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_param_if.slave ctl,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              mosi,
    input  logic              miso,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int CNT_W = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;
    state_t state_q, state_d;

    logic [DIV_W-1:0]      div_q;
    logic [CNT_W-1:0]      edge_q, edge_k;
    logic [DATA_WIDTH-1:0] tx_q, tx_nxt, rx_q;
    logic                  cpol_q, cpha_q, lsb_q;
    logic                  start, tick, toggle, drive, sample, finish, rx_bit;
    logic [NUM_CS-1:0]     cs_sel_n;

    assign start  = ctl.load && ctl.ready;
    assign tick   = (state_q != IDLE) && (div_q == DIV_LAST);
    assign edge_k = edge_q + CNT_W'(1);
    assign tx_nxt = lsb_q ? (tx_q >> 1) : (tx_q << 1);

`ifdef SPI_LOOPBACK_EN
    logic lb_q;
    assign rx_bit = lb_q ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    // Out-of-range selects decode to no active line; loopback keeps every slave deselected.
    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (ctl.cs_sel == CS_SEL_W'(i)) cs_sel_n[i] = 1'b0;
`ifdef SPI_LOOPBACK_EN
        if (loopback) cs_sel_n = '1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SETUP;
            SETUP:    if (tick) state_d = TRANSFER;
            TRANSFER: if (tick && edge_k == EDGE_LAST) state_d = HOLD;
            HOLD:     if (tick) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // edge_k is the SCLK edge number taken on this tick; odd = leading edge.
    always_comb begin
        toggle = 1'b0;
        drive  = 1'b0;
        sample = 1'b0;
        finish = 1'b0;
        case (state_q)
            SETUP, TRANSFER: begin
                if (tick) begin
                    toggle = 1'b1;
                    sample = edge_k[0] ^ cpha_q;
                    drive  = cpha_q ? (edge_k[0] && edge_k != CNT_W'(1))
                                    : (!edge_k[0] && edge_k != EDGE_LAST);
                end
            end
            HOLD:    finish = tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            edge_q       <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            lsb_q        <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_q         <= 1'b0;
`endif
            ctl.data_out <= '0;
            ctl.ready    <= 1'b1;
            ctl.done     <= 1'b0;
            mosi         <= 1'b0;
            sclk         <= 1'b0;
            cs_n         <= '1;
        end else begin
            ctl.done <= 1'b0;
            if (start) begin
                tx_q      <= ctl.data_in;
                cpol_q    <= ctl.cpol;
                cpha_q    <= ctl.cpha;
                lsb_q     <= ctl.lsb_first;
`ifdef SPI_LOOPBACK_EN
                lb_q      <= loopback;
`endif
                ctl.ready <= 1'b0;
                cs_n      <= cs_sel_n;
                sclk      <= ctl.cpol;
                mosi      <= ctl.lsb_first ? ctl.data_in[0] : ctl.data_in[DATA_WIDTH-1];
                div_q     <= '0;
                edge_q    <= '0;
            end else if (state_q != IDLE) begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
                if (toggle) begin
                    sclk   <= ~sclk;
                    edge_q <= edge_k;
                end
                if (drive) begin
                    tx_q <= tx_nxt;
                    mosi <= lsb_q ? tx_nxt[0] : tx_nxt[DATA_WIDTH-1];
                end
                if (sample)
                    rx_q <= lsb_q ? {rx_bit, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], rx_bit};
                if (finish) begin
                    cs_n         <= '1;
                    ctl.data_out <= rx_q;
                    ctl.done     <= 1'b1;
                    ctl.ready    <= 1'b1;
                end
            end
        end
    end
endmodule
